div_unit: RTL and testbench

Iterative 32-bit signed/unsigned divider for the EX stage, sitting directly downstream of the ALU-control decoder. It consumes the 8-bit `alucontrol` code together with the two register operands. It starts a multi-cycle restoring division only for the DIV and DIVU opcodes, and holds the pipeline with `stall` while it runs. When it finishes it delivers remainder and quotient for the HI/LO registers.

---
 rtl/div_unit_pkg.sv | 9 +
 rtl/div_unit_core.sv | 54 +++++
 rtl/div_unit.sv | 121 ++++++++++++
 tb/tb_div_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared EX-stage defines: ALU-control opcodes used by div_unit.
// Imported by the divider and anything decoding alucontrol.
package div_unit_pkg;

  localparam logic [7:0] EXE_ADD_OP  = 8'b0010_0000;
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit_core.sv
// div_core: unsigned restoring shift-subtract datapath,
// one quotient bit per step, WIDTH steps per division.
module div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH:0] pr;
  logic [2*WIDTH:0] sh;
  logic [2*WIDTH:0] pr_nx;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    cnt;

  // quo/rem reflect the value after this step, so the
  // caller can capture them on the final step's edge
  always_comb begin
    sh    = {pr[2*WIDTH-1:0], 1'b0};
    diff  = sh[2*WIDTH:WIDTH] - {1'b0, dvsr};
    pr_nx = sh;
    if (!diff[WIDTH])
      pr_nx = {diff, sh[WIDTH-1:1], 1'b1};
    done = step && (cnt == CW'(WIDTH - 1));
    quo  = pr_nx[WIDTH-1:0];
    rem  = pr_nx[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pr   <= '0;
      dvsr <= '0;
      cnt  <= '0;
    end else if (load) begin
      pr   <= {{(WIDTH+1){1'b0}}, dividend};
      dvsr <= divisor;
      cnt  <= '0;
    end else if (step) begin
      pr  <= pr_nx;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// EX-stage iterative DIV/DIVU unit with sign fix and stall.
// Optional divide-by-zero fast path: DIV_ZERO_DETECT_EN.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       alucontrol,
  input  logic             valid,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef DIV_ZERO_DETECT_EN
  ,
  output logic             div_zero
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t state;

  logic             is_div;
  logic             is_divu;
  logic             start;
  logic             load;
  logic             zskip;
  logic             qneg;
  logic             rneg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             core_done;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  assign is_div  = alucontrol == EXE_DIV_OP;
  assign is_divu = alucontrol == EXE_DIVU_OP;
  assign start   = valid && !cancel
                && (is_div || is_divu)
                && state == S_IDLE;

`ifdef DIV_ZERO_DETECT_EN
  assign zskip = b == '0;
`else
  assign zskip = 1'b0;
`endif

  assign load  = start && !zskip;
  assign stall = start || state == S_CALC;

  assign a_mag = (is_div && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_div && b[WIDTH-1]) ? -b : b;

  div_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (state == S_CALC),
    .dividend (a_mag),
    .divisor  (b_mag),
    .done     (core_done),
    .quo      (quo),
    .rem      (rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
      ready <= 1'b0;
      hi    <= '0;
      lo    <= '0;
`ifdef DIV_ZERO_DETECT_EN
      div_zero <= 1'b0;
`endif
    end else begin
      ready <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      div_zero <= 1'b0;
`endif
      case (state)
        S_IDLE: if (start) begin
          qneg  <= is_div && (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg  <= is_div && a[WIDTH-1];
          state <= S_CALC;
`ifdef DIV_ZERO_DETECT_EN
          if (zskip) begin
            state    <= S_DONE;
            ready    <= 1'b1;
            hi       <= a;
            lo       <= '1;
            div_zero <= 1'b1;
          end
`endif
        end
        S_CALC: if (cancel) begin
          state <= S_IDLE;
        end else if (core_done) begin
          state <= S_DONE;
          ready <= 1'b1;
          lo    <= qneg ? -quo : quo;
          hi    <= rneg ? -rem : rem;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit (WIDTH=32).
// Tracks DIV_ZERO_DETECT_EN to pick zero-divisor expectations.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  alucontrol;
  logic        valid;
  logic        cancel;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall;
  logic        ready;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef DIV_ZERO_DETECT_EN
  logic        div_zero;
`endif

  int errs = 0;
  int chks = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .alucontrol (alucontrol),
    .valid      (valid),
    .cancel     (cancel),
    .a          (a),
    .b          (b),
    .stall      (stall),
    .ready      (ready),
    .hi         (hi),
    .lo         (lo)
`ifdef DIV_ZERO_DETECT_EN
    ,
    .div_zero   (div_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    chks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(
    input string       tag,
    input logic [7:0]  op,
    input logic [31:0] da,
    input logic [31:0] db,
    input logic [31:0] elo,
    input logic [31:0] ehi,
    input int          elat,
    input logic        edz
  );
    int cyc;
    int gap;
    alucontrol = op;
    valid = 1'b1;
    a = da;
    b = db;
    #1;
    check({tag, ".issue_stall"}, 32'(stall), 32'd1);
    tick();
    valid = 1'b0;
    alucontrol = 8'h00;
    cyc = 1;
    gap = 0;
    while (ready !== 1'b1 && cyc < 200) begin
      if (stall !== 1'b1) gap++;
      tick();
      cyc++;
    end
    check({tag, ".latency"}, 32'(cyc), 32'(elat));
    check({tag, ".calc_stall"}, 32'(gap), 32'd0);
    check({tag, ".lo"}, lo, elo);
    check({tag, ".hi"}, hi, ehi);
    check({tag, ".done_stall"}, 32'(stall), 32'd0);
`ifdef DIV_ZERO_DETECT_EN
    check({tag, ".div_zero"}, 32'(div_zero), 32'(edz));
`else
    if (edz) check({tag, ".dz_arg"}, 32'(edz), 32'd1);
`endif
    tick();
    check({tag, ".ready_pulse"}, 32'(ready), 32'd0);
  endtask

  initial begin
    int pulses;
    int busy;
    int zlat;
    rst = 1'b1;
    alucontrol = 8'h00;
    valid = 1'b0;
    cancel = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.ready", 32'(ready), 32'd0);
    check("rst.hi", hi, 32'd0);
    check("rst.lo", lo, 32'd0);
`ifdef DIV_ZERO_DETECT_EN
    check("rst.div_zero", 32'(div_zero), 32'd0);
`endif
    rst = 1'b0;
    tick();

    run_div("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7,
            32'd14, 32'd2, 33, 1'b0);
    run_div("div_m7_2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2,
            32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0);
    run_div("div_7_m2", EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE,
            32'hFFFF_FFFD, 32'd1, 33, 1'b0);

    // cancel in CALC cycle 10 of DIVU 1000/3
    alucontrol = EXE_DIVU_OP;
    valid = 1'b1;
    a = 32'd1000;
    b = 32'd3;
    #1;
    check("cancel.issue_stall", 32'(stall), 32'd1);
    tick();
    valid = 1'b0;
    alucontrol = 8'h00;
    repeat (9) tick();
    cancel = 1'b1;
    #1;
    check("cancel.calc_stall", 32'(stall), 32'd1);
    tick();
    cancel = 1'b0;
    check("cancel.stall_drop", 32'(stall), 32'd0);
    pulses = 0;
    busy = 0;
    repeat (40) begin
      if (ready === 1'b1) pulses++;
      if (stall === 1'b1) busy++;
      tick();
    end
    check("cancel.no_ready", 32'(pulses), 32'd0);
    check("cancel.idle", 32'(busy), 32'd0);
    check("cancel.hi_kept", hi, 32'd1);
    check("cancel.lo_kept", lo, 32'hFFFF_FFFD);

    run_div("divu_9_4", EXE_DIVU_OP, 32'd9, 32'd4,
            32'd2, 32'd1, 33, 1'b0);
    run_div("div_ovf", EXE_DIV_OP, 32'h8000_0000,
            32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 1'b0);
    run_div("divu_5_10", EXE_DIVU_OP, 32'd5, 32'd10,
            32'd0, 32'd5, 33, 1'b0);
    run_div("divu_max_1", EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd1,
            32'hFFFF_FFFF, 32'd0, 33, 1'b0);
    run_div("div_m100_m7", EXE_DIV_OP, 32'hFFFF_FF9C,
            32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 33, 1'b0);

    // non-divide opcode
    alucontrol = EXE_ADD_OP;
    valid = 1'b1;
    a = 32'd100;
    b = 32'd7;
    #1;
    check("add.stall", 32'(stall), 32'd0);
    tick();
    valid = 1'b0;
    check("add.idle", 32'(stall), 32'd0);
    check("add.ready", 32'(ready), 32'd0);

    // divide with valid low
    alucontrol = EXE_DIV_OP;
    #1;
    check("novalid.stall", 32'(stall), 32'd0);
    tick();
    check("novalid.idle", 32'(stall), 32'd0);
    check("novalid.ready", 32'(ready), 32'd0);

    // divide with cancel in the issue cycle
    valid = 1'b1;
    cancel = 1'b1;
    #1;
    check("startcan.stall", 32'(stall), 32'd0);
    tick();
    valid = 1'b0;
    cancel = 1'b0;
    alucontrol = 8'h00;
    check("startcan.idle", 32'(stall), 32'd0);
    check("startcan.ready", 32'(ready), 32'd0);
    check("startcan.lo_kept", lo, 32'd14);
    tick();

`ifdef DIV_ZERO_DETECT_EN
    zlat = 1;
`else
    zlat = 33;
`endif
    run_div("divu_zero", EXE_DIVU_OP, 32'h0000_1234, 32'd0,
            32'hFFFF_FFFF, 32'h0000_1234, zlat, 1'b1);

    // reset mid-division discards it
    alucontrol = EXE_DIVU_OP;
    valid = 1'b1;
    a = 32'd100;
    b = 32'd7;
    tick();
    valid = 1'b0;
    alucontrol = 8'h00;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst.stall", 32'(stall), 32'd0);
    check("midrst.ready", 32'(ready), 32'd0);
    check("midrst.hi", hi, 32'd0);
    check("midrst.lo", lo, 32'd0);
    pulses = 0;
    repeat (40) begin
      if (ready === 1'b1) pulses++;
      tick();
    end
    check("midrst.no_ready", 32'(pulses), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
